reg_file_scoreboard: RTL and testbench

Parametrised general-purpose register file for the pipelined core: N registered read ports, one write-back port with write-to-read bypass, register 0 hardwired to zero, and a per-register pending (scoreboard) bit set at issue and cleared at write-back. It sits between decode (read and issue side) and write-back (write side). It replaces the fixed 16×32, two-port, edge-on-write-enable register file.

---
 rtl/reg_file_scoreboard_pkg.sv | 9 +
 rtl/reg_file_scoreboard_read_port.sv | 47 ++++
 rtl/reg_file_scoreboard.sv | 101 ++++++++++
 tb/tb_reg_file_scoreboard.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_scoreboard_pkg.sv
// Shared register-file constants: default geometry and the reset value.
package reg_file_scoreboard_pkg;

    localparam int RF_DATA_W     = 32;
    localparam int RF_ADDR_W     = 4;
    localparam int RF_MAX_DATA_W = 64;
    localparam logic [RF_MAX_DATA_W-1:0] RF_RESET_VAL = '0;

endpackage

// File: rtl/reg_file_scoreboard_read_port.sv
// One registered read port: array mux, write-back bypass and captured pending bit.
module rf_read_port
    import reg_file_scoreboard_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DEPTH  = 2 ** RF_ADDR_W
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] regs_i [DEPTH],
    input  logic [DEPTH-1:0]  pend_d_i,
    input  logic              wr_eff_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_busy_o
);

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_busy_q, rd_busy_d;

    // Busy comes from the next-state pend vector so a same-edge write-back reads as free.
    always_comb begin
        rd_data_d = regs_i[rd_addr_i];
        if (wr_eff_i && (wr_addr_i == rd_addr_i)) begin
            rd_data_d = wr_data_i;
        end
        rd_busy_d = pend_d_i[rd_addr_i];
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_data_q <= DATA_W'(RF_RESET_VAL);
            rd_busy_q <= 1'b0;
        end else if (en_i) begin
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_busy_o = rd_busy_q;

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with N registered read ports, write-back bypass, hardwired r0
// and a per-register pending scoreboard with an incrementally kept busy count.
module reg_file_scoreboard
    import reg_file_scoreboard_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int N_RD     = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          en,
    input  logic [N_RD*ADDR_W-1:0]        rd_addr,
    output logic [N_RD*DATA_W-1:0]        rd_data,
    output logic [N_RD-1:0]               rd_busy,
    input  logic                          wr_en,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          iss_en,
    input  logic [ADDR_W-1:0]             iss_addr,
    output logic [ADDR_W:0]               busy_count,
    output logic [(2**ADDR_W)*DATA_W-1:0] regs_flat
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic [ADDR_W:0]   busy_count_q, busy_count_d;
    logic              wr_eff, iss_eff, cnt_inc, cnt_dec;

    // wr_en and iss_en are single-cycle strobes with no back-pressure: each is
    // acted on at the edge where it is high; en stalls issue but never write-back.
    assign wr_eff  = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign iss_eff = iss_en && en && !((ZERO_REG != 0) && (iss_addr == '0));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs_q[r] <= DATA_W'(RF_RESET_VAL);
            end
        end else if (wr_eff) begin
            regs_q[wr_addr] <= wr_data;
        end
    end

    // Set is applied last so a new producer supersedes a same-cycle write-back.
    always_comb begin
        pend_d = pend_q;
        if (wr_en) begin
            pend_d[wr_addr] = 1'b0;
        end
        if (iss_eff) begin
            pend_d[iss_addr] = 1'b1;
        end
    end

    always_comb begin
        cnt_inc      = iss_eff && !pend_q[iss_addr];
        cnt_dec      = wr_en && pend_q[wr_addr] && !(iss_eff && (iss_addr == wr_addr));
        busy_count_d = busy_count_q + (ADDR_W+1)'(cnt_inc) - (ADDR_W+1)'(cnt_dec);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q       <= '0;
            busy_count_q <= '0;
        end else begin
            pend_q       <= pend_d;
            busy_count_q <= busy_count_d;
        end
    end

    assign busy_count = busy_count_q;

    for (genvar r = 0; r < DEPTH; r++) begin : g_flat
        assign regs_flat[r*DATA_W +: DATA_W] = regs_q[r];
    end

    for (genvar i = 0; i < N_RD; i++) begin : g_port
        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_port (
            .clock_i   (clock),
            .reset_n_i (reset_n),
            .en_i      (en),
            .rd_addr_i (rd_addr[i*ADDR_W +: ADDR_W]),
            .regs_i    (regs_q),
            .pend_d_i  (pend_d),
            .wr_eff_i  (wr_eff),
            .wr_addr_i (wr_addr),
            .wr_data_i (wr_data),
            .rd_data_o (rd_data[i*DATA_W +: DATA_W]),
            .rd_busy_o (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench for reg_file_scoreboard with default parameters (32x16, 2 ports, r0 hardwired).
module tb_reg_file_scoreboard;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         en;
    logic [7:0]   rd_addr;
    logic [63:0]  rd_data;
    logic [1:0]   rd_busy;
    logic         wr_en;
    logic [3:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         iss_en;
    logic [3:0]   iss_addr;
    logic [4:0]   busy_count;
    logic [511:0] regs_flat;

    int n_assert = 0;
    int n_fail   = 0;

    reg_file_scoreboard dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .iss_en     (iss_en),
        .iss_addr   (iss_addr),
        .busy_count (busy_count),
        .regs_flat  (regs_flat)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_data"}, rd_data, 64'h0);
        check({tag, "_rd_busy"}, rd_busy, 2'b00);
        check({tag, "_busy_count"}, busy_count, 5'd0);
        for (int r = 0; r < 16; r++) begin
            check({tag, "_reg"}, regs_flat[r*32 +: 32], 32'h0);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        en       = 1'b1;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;

        step();
        step();
        check_all_zero("reset");
        reset_n = 1'b1;

        // Read every index on both ports after reset.
        for (int a = 0; a < 16; a++) begin
            set_rd(4'(a), 4'(15 - a));
            step();
            check("init_rd0", rd_data[31:0], 32'h0);
            check("init_rd1", rd_data[63:32], 32'h0);
            check("init_busy", rd_busy, 2'b00);
        end
        check("init_count", busy_count, 5'd0);

        // Same-edge bypass of a write to r5.
        set_rd(4'd5, 4'd6);
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
        step();
        check("bypass_rd0", rd_data[31:0], 32'hDEADBEEF);
        check("bypass_rd1", rd_data[63:32], 32'h0);
        check("bypass_busy", rd_busy, 2'b00);
        check("bypass_array", regs_flat[5*32 +: 32], 32'hDEADBEEF);
        wr_en = 1'b0;
        step();
        step();
        check("array_rd0", rd_data[31:0], 32'hDEADBEEF);

        // Writes and issues to r0 are ignored.
        set_rd(4'd0, 4'd5);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 32'h12345678;
        iss_en = 1'b1; iss_addr = 4'd0;
        step();
        check("r0_rd0", rd_data[31:0], 32'h0);
        check("r0_busy", rd_busy, 2'b00);
        check("r0_count", busy_count, 5'd0);
        check("r0_array", regs_flat[31:0], 32'h0);
        wr_en = 1'b0; iss_en = 1'b0;
        step();
        check("r0_rd0_later", rd_data[31:0], 32'h0);

        // Issue r3 then r7; reads at the issue edge already see busy.
        set_rd(4'd3, 4'd7);
        iss_en = 1'b1; iss_addr = 4'd3;
        step();
        check("iss3_busy", rd_busy, 2'b01);
        check("iss3_count", busy_count, 5'd1);
        iss_addr = 4'd7;
        step();
        check("iss7_busy", rd_busy, 2'b11);
        check("iss7_count", busy_count, 5'd2);

        // Issue and write-back r3 together: stays pending, data bypassed.
        iss_addr = 4'd3;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hA5A5A5A5;
        step();
        check("iss_wb3_busy", rd_busy, 2'b11);
        check("iss_wb3_data", rd_data[31:0], 32'hA5A5A5A5);
        check("iss_wb3_count", busy_count, 5'd2);

        // Write-back r7 clears it.
        iss_en = 1'b0;
        wr_addr = 4'd7; wr_data = 32'h00000077;
        step();
        check("wb7_busy", rd_busy, 2'b01);
        check("wb7_data", rd_data[63:32], 32'h00000077);
        check("wb7_count", busy_count, 5'd1);

        // Stall three cycles while poking r9.
        en = 1'b0;
        iss_en = 1'b1; iss_addr = 4'd9;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h99990009;
        for (int k = 0; k < 3; k++) begin
            set_rd(4'(9 + k), 4'(1 + k));
            step();
            check("stall_rd0", rd_data[31:0], 32'hA5A5A5A5);
            check("stall_rd1", rd_data[63:32], 32'h00000077);
            check("stall_busy", rd_busy, 2'b01);
            check("stall_count", busy_count, 5'd1);
        end
        check("stall_array9", regs_flat[9*32 +: 32], 32'h99990009);
        en = 1'b1; iss_en = 1'b0; wr_en = 1'b0;
        set_rd(4'd9, 4'd5);
        step();
        check("post_stall_rd0", rd_data[31:0], 32'h99990009);
        check("post_stall_busy", rd_busy, 2'b00);
        check("post_stall_count", busy_count, 5'd1);

        // Build four pending registers, then reset mid-cycle.
        iss_en = 1'b1;
        iss_addr = 4'd1; step();
        iss_addr = 4'd2; step();
        iss_addr = 4'd4; step();
        iss_en = 1'b0;
        set_rd(4'd9, 4'd3);
        step();
        check("pre_rst_count", busy_count, 5'd4);
        check("pre_rst_rd0", rd_data[31:0], 32'h99990009);
        check("pre_rst_busy", rd_busy, 2'b10);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        step();
        reset_n = 1'b1;
        step();
        check("after_rst_count", busy_count, 5'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
